// File: rtl/key_sw_io_dev.sv
// key_sw_io_dev
//   Memory-mapped KEY/SW input responder on the MEM-stage data bus.
//   Synchronises and debounces the raw board pins, exposes the debounced
//   values through read-only DATA registers, and keeps per-device sticky
//   Ready/Overrun status plus an interrupt enable in the CTRL registers.
//
// Ports
//   clk     system clock
//   reset   asynchronous active-low reset
//   addr    bus byte address
//   rd_en   one-cycle load strobe (qualifies the Ready-clear side effect)
//   wrt_en  store strobe
//   wdata   store data
//   rdata   combinational read data (0 when not hit)
//   hit     address matches one of the four registers
//   KEY     raw push buttons, active-low
//   SW      raw slide switches
//   irq     registered level interrupt request
//
// CTRL layout: bit0 Ready, bit2 Overrun, bit4 IE, all others read 0.

module key_sw_debounce #(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sync_next,
    input  logic [W-1:0] sync_now,
    output logic [W-1:0] deb,
    output logic         upd
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          restart;

    // The first synchroniser stage already holds next cycle's synced value,
    // so a change is caught the cycle it lands rather than one cycle later.
    assign restart = (sync_next != sync_now) || (sync_now == deb);
    assign upd     = !restart && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            deb <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            deb <= sync_now;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

module key_sw_io_dev #(
    parameter int               DBITS           = 32,
    parameter int               DEBOUNCE_CYCLES = 10000,
    parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SDATA      = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             rd_en,
    input  logic             wrt_en,
    input  logic [DBITS-1:0] wdata,
    output logic [DBITS-1:0] rdata,
    output logic             hit,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic             irq
);
    logic [3:0] key_s1, key_s2;
    logic [9:0] sw_s1, sw_s2;
    logic [3:0] key_deb;
    logic [9:0] sw_deb;
    logic       key_upd, sw_upd;

    logic k_ready, k_ovr, k_ie;
    logic s_ready, s_ovr, s_ie;

    logic rd_kdata, rd_sdata, wr_kctrl, wr_sctrl;
    logic unused_wdata;

    assign unused_wdata = ^{wdata[DBITS-1:5], wdata[3], wdata[1:0]};

    // Buttons idle high, so their synchroniser resets to the released level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    key_sw_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_deb (
        .clk       (clk),
        .reset     (reset),
        .sync_next (~key_s1),
        .sync_now  (~key_s2),
        .deb       (key_deb),
        .upd       (key_upd)
    );

    key_sw_debounce #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_deb (
        .clk       (clk),
        .reset     (reset),
        .sync_next (sw_s1),
        .sync_now  (sw_s2),
        .deb       (sw_deb),
        .upd       (sw_upd)
    );

    assign rd_kdata = rd_en  && (addr == ADDR_KDATA);
    assign rd_sdata = rd_en  && (addr == ADDR_SDATA);
    assign wr_kctrl = wrt_en && (addr == ADDR_KCTRL);
    assign wr_sctrl = wrt_en && (addr == ADDR_SCTRL);

    // A read landing with an update has consumed the old value, so the new
    // one is not an overrun; set always beats clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_ready <= 1'b0;
            k_ovr   <= 1'b0;
            k_ie    <= 1'b0;
            s_ready <= 1'b0;
            s_ovr   <= 1'b0;
            s_ie    <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (key_upd)
                k_ready <= 1'b1;
            else if (rd_kdata)
                k_ready <= 1'b0;

            if (key_upd && k_ready && !rd_kdata)
                k_ovr <= 1'b1;
            else if (wr_kctrl && !wdata[2])
                k_ovr <= 1'b0;

            if (wr_kctrl)
                k_ie <= wdata[4];

            if (sw_upd)
                s_ready <= 1'b1;
            else if (rd_sdata)
                s_ready <= 1'b0;

            if (sw_upd && s_ready && !rd_sdata)
                s_ovr <= 1'b1;
            else if (wr_sctrl && !wdata[2])
                s_ovr <= 1'b0;

            if (wr_sctrl)
                s_ie <= wdata[4];

            irq <= (k_ie && k_ready) || (s_ie && s_ready);
        end
    end

    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        case (addr)
            ADDR_KDATA: rdata = DBITS'(key_deb);
            ADDR_SDATA: rdata = DBITS'(sw_deb);
            ADDR_KCTRL: rdata = DBITS'({k_ie, 1'b0, k_ovr, 1'b0, k_ready});
            ADDR_SCTRL: rdata = DBITS'({s_ie, 1'b0, s_ovr, 1'b0, s_ready});
            default:    hit   = 1'b0;
        endcase
    end
endmodule
